fadd_share_sched: RTL
=====================

Name: fadd_share_sched

Overview:
Round-robin scheduler that shares one half-precision floating-point add/sub datapath (the `cadd` core, fixed latency, no backpressure) between N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one operation per clock and tracks each issued operation's requester ID through a tag pipeline matched to the core latency. It routes each result and flag back to the issuing requester. It sits between the optimizer update engines and the single shared FP adder in the FPGA deployment.

Parameters:
- EXP, 5, exponent width.
- FRA, 10, stored fraction width; word width W = EXP+FRA+1.
- N_REQ, 4, number of requesters (2..8); ID width IDW = clog2(N_REQ).
- ADD_LAT, 2, cycles from core input valid to core result (1..8).

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; handshake completes when valid&ready.
- req_a  in  N_REQ*W  operand A, requester i at bits [i*W +: W].
- req_b  in  N_REQ*W  operand B, same packing.
- req_op  in  N_REQ  0=add, 1=sub (used only with the optional feature).
- drain  in  1  stop granting new operations and flush in-flight ones.
- idle  out  1  high in IDLE state with nothing in flight.
- add_valid  out  1  issue strobe to the core.
- add_a  out  W  core operand A.
- add_b  out  W  core operand B.
- add_y  in  W  core result, valid ADD_LAT cycles after add_valid.
- add_flag  in  3  core status flag, aligned with add_y.
- rsp_valid  out  N_REQ  one-hot result strobe to the issuing requester.
- rsp_y  out  W  result, registered.
- rsp_flag  out  3  flag, registered.

Behaviour:
- Reset (async assert, sync release): every output is 0 except idle, which is 1. The RR pointer is 0, the tag pipeline is cleared, the in-flight counter is 0, and the FSM is in IDLE.
- FSM states:
  - IDLE to RUN: any req_valid and drain=0.
  - RUN to DRAIN: drain=1.
  - RUN to IDLE: no req_valid and in-flight count = 0.
  - DRAIN to IDLE: in-flight count = 0 and drain=0.
  - DRAIN holds while drain=1, even after the flush completes.
- Grant rules:
  - Grants happen only in RUN and in IDLE-with-request (same-cycle grant on the IDLE to RUN transition).
  - The grant goes to the first requester with req_valid, searching from the RR pointer upward with wrap.
  - req_ready is combinational one-hot to the granted requester and 0 for all others. It is all-zero in DRAIN and whenever drain=1.
  - On a grant, the RR pointer becomes (granted+1) mod N_REQ. It is unchanged when there is no grant.
- Issue: add_valid, add_a and add_b are registered from the granted operands one cycle after the handshake. Throughput is one operation per clock.
- Tag pipeline: ADD_LAT+1 stages of {valid, ID}, stage 0 loaded at issue. When the last stage is valid, the block registers rsp_y=add_y and rsp_flag=add_flag, and pulses rsp_valid[ID] for one cycle.
- Total latency from handshake to rsp_valid: ADD_LAT+2 cycles.
- In-flight counter:
  - Width clog2(ADD_LAT+3).
  - Increments on grant and decrements on rsp_valid.
  - Simultaneous grant and rsp_valid leave it unchanged.
  - It can never exceed ADD_LAT+2, so no overflow check is required.
- Responses have no backpressure; requesters must accept rsp_valid when it pulses.
- If req_valid drops without a handshake, nothing is issued.
- If operands change while valid is high and ready is low, the values present in the grant cycle are used.
- N_REQ=1 degenerates to a pass-through with a constant RR pointer.
- Reset mid-operation discards all in-flight tags. No rsp_valid is produced for them, even though the core still emits results.

Optional Feature:
- FADD_SCHED_SUB_EN:
  - Defined: req_op=1 inverts the sign bit (MSB) of B before issue, so the result is A−B.
  - Undefined: req_op is ignored, add_b always equals req_b, and the op logic is absent.

Decomposition:
- Shared package `fadd_sched_pkg`:
  - W and IDW derivation functions.
  - FSM state enum {IDLE, RUN, DRAIN}.
  - Tag struct {valid, id}.
- Sub-module `rr_arbiter`: inputs N_REQ-wide request vector and pointer; outputs one-hot grant, granted index and any-grant. Purely combinational.
- The remainder (FSM, issue registers, tag pipeline, counter) lives in the top module.

Test Plan:
- Single request: requester 0 sends A=3c00, B=3c00 with core stub ADD_LAT=2. Expect add_valid one cycle after the handshake, rsp_valid=0001 four cycles after the handshake, rsp_y=4000, idle returning to 1.
- Full contention: all four requesters valid continuously for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3, rsp_valid order identical, and each requester receiving exactly 2 results.
- Sparse fairness: requesters 1 and 3 valid, pointer at 2. Expect grants 3,1,3,1.
- Drain: assert drain with 3 in flight. Expect req_ready=0 immediately, all 3 responses delivered, no new add_valid, and idle=1 only after drain is deasserted.
- Sub feature: with FADD_SCHED_SUB_EN defined, req_op=1, A=4000, B=3c00. Expect add_b=bc00 and rsp_y=3c00. With the macro undefined, expect add_b=3c00.
- Reset mid-flight: pull aresetn low with 2 in flight. Expect all outputs 0 and idle=1 at once, and no rsp_valid after release.

Source files
------------

// File: rtl/fadd_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : fadd_sched_pkg
// Purpose  : Shared types and helpers for the FP add/sub sharing scheduler:
//            word/ID width derivation, FSM state encoding, tag record.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fadd_sched_pkg;

  // Tag ID field is sized for the largest supported requester count (8).
  localparam int TAG_IDW = 3;

  function automatic int calc_w(input int exp_w, input int fra_w);
    return exp_w + fra_w + 1;
  endfunction

  // A single requester still needs a 1-bit index so the vectors stay legal.
  function automatic int calc_idw(input int n_req);
    return (n_req <= 1) ? 1 : $clog2(n_req);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/fadd_share_sched_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Picks the first asserted
//            request at or above the pointer, wrapping around.
// Ports    : req       - request vector
//            ptr       - search start index
//            grant     - one-hot grant
//            grant_idx - index of the granted request
//            any_grant - a request was found
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import fadd_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = calc_idw(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             any_grant
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // k is the distance from the pointer; i is the candidate that lies
    // k positions above it modulo N_REQ.
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_grant && req[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + N_REQ))) begin
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fadd_share_sched.sv
//------------------------------------------------------------------------------
// Module   : fadd_share_sched
// Purpose  : Shares one fixed-latency half-precision add/sub core between
//            N_REQ requesters. Round-robin grant, one issue per clock, a tag
//            pipeline matched to the core latency routes results back.
// Ports    : clk, aresetn            - clock, async active-low reset
//            req_valid/ready/a/b/op  - per-requester operand handshake
//            drain                   - stop granting, flush in-flight ops
//            idle                    - IDLE state with nothing in flight
//            add_valid/a/b           - registered issue to the core
//            add_y/add_flag          - core result, ADD_LAT after add_valid
//            rsp_valid/y/flag        - registered, one-hot routed response
// Config   : FADD_SCHED_SUB_EN - when defined, req_op=1 flips B's sign so
//            the core computes A-B; otherwise req_op is ignored.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fadd_share_sched
  import fadd_sched_pkg::*;
#(
  parameter int EXP     = 5,
  parameter int FRA     = 10,
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*(EXP+FRA+1)-1:0]   req_a,
  input  logic [N_REQ*(EXP+FRA+1)-1:0]   req_b,
  input  logic [N_REQ-1:0]               req_op,
  input  logic                           drain,
  output logic                           idle,
  output logic                           add_valid,
  output logic [EXP+FRA:0]               add_a,
  output logic [EXP+FRA:0]               add_b,
  input  logic [EXP+FRA:0]               add_y,
  input  logic [2:0]                     add_flag,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [EXP+FRA:0]               rsp_y,
  output logic [2:0]                     rsp_flag
);

  localparam int W    = calc_w(EXP, FRA);
  localparam int IDW  = calc_idw(N_REQ);
  localparam int CNTW = $clog2(ADD_LAT + 3);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_ptr;
  logic [CNTW-1:0]    r_inflight;
  tag_t               r_tag [0:ADD_LAT];

  logic               w_grant_en;
  logic               w_grant;
  logic [N_REQ-1:0]   w_arb_gnt;
  logic [IDW-1:0]     w_gnt_idx;
  logic               w_any;
  logic [W-1:0]       w_sel_a;
  logic [W-1:0]       w_sel_b;
  logic [W-1:0]       w_issue_b;
  logic [N_REQ-1:0]   w_rsp_dec;
  tag_t               w_last;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_arb_gnt),
    .grant_idx (w_gnt_idx),
    .any_grant (w_any)
  );

  // FSM next state and handshake outputs. Granting is allowed in IDLE too,
  // so the first request is accepted in the same cycle IDLE moves to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = !drain && (r_state != ST_DRAIN);
    req_ready   = w_grant_en ? w_arb_gnt : '0;
    w_grant     = w_grant_en && w_any;
    idle        = (r_state == ST_IDLE) && (r_inflight == '0);
    unique case (r_state)
      ST_IDLE:  if ((|req_valid) && !drain) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (drain)                                     w_state_nxt = ST_DRAIN;
        else if (!(|req_valid) && r_inflight == '0)    w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: if (!drain && r_inflight == '0)        w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand mux driven by the one-hot grant.
`ifdef FADD_SCHED_SUB_EN
  logic w_sel_op;
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_sel_a  = req_a[i*W +: W];
        w_sel_b  = req_b[i*W +: W];
        w_sel_op = req_op[i];
      end
    end
  end
  // Subtraction is an addition with B's sign bit flipped.
  assign w_issue_b = w_sel_b ^ {w_sel_op, {(W-1){1'b0}}};
`else
  logic w_unused_op;
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_sel_a = req_a[i*W +: W];
        w_sel_b = req_b[i*W +: W];
      end
    end
  end
  assign w_issue_b   = w_sel_b;
  assign w_unused_op = ^req_op;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant)
        r_ptr <= (w_gnt_idx == IDW'(N_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      add_valid <= w_grant;
      if (w_grant) begin
        add_a <= w_sel_a;
        add_b <= w_issue_b;
      end
    end
  end

  // Stage 0 is loaded together with the issue registers, so the last stage
  // lines up with the core result ADD_LAT cycles later.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k <= ADD_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0].valid <= w_grant;
      r_tag[0].id    <= TAG_IDW'(w_gnt_idx);
      for (int k = 1; k <= ADD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_last = r_tag[ADD_LAT];

  always_comb begin
    w_rsp_dec = '0;
    for (int i = 0; i < N_REQ; i++)
      w_rsp_dec[i] = w_last.valid && (w_last.id == TAG_IDW'(i));
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
      rsp_flag  <= '0;
    end else begin
      rsp_valid <= w_rsp_dec;
      if (w_last.valid) begin
        rsp_y    <= add_y;
        rsp_flag <= add_flag;
      end
    end
  end

  // An op is counted from its grant until its response pulse retires.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_grant, |rsp_valid})
        2'b10:   r_inflight <= r_inflight + CNTW'(1);
        2'b01:   r_inflight <= r_inflight - CNTW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule

`default_nettype wire
